// File: rtl/uart_rx_engine_if.sv
// rtl/uart_rx_engine_if.sv - register-side bundle of the UART receive engine
//
// Groups the framing/baud controls, the host read strobe and the received
// character with its status flags.
//   baud_k  [18:0]  clock cycles per bit
//   eight           1 = 8 data bits, 0 = 7 data bits
//   pen             parity enable
//   ohel            parity sense, 1 = odd, 0 = even
//   read            one-cycle pulse, host consumed the character
//   rx_data [7:0]   received character
//   rxrdy           character available
//   perr            parity error on the latched character
//   ferr            framing error on the latched character
//   ovf             overrun, sticky until read
// master = host/register side, slave = receive engine.
interface uart_rx_engine_if;
    logic [18:0] baud_k;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        read;
    logic [7:0]  rx_data;
    logic        rxrdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    modport master (
        output baud_k, eight, pen, ohel, read,
        input  rx_data, rxrdy, perr, ferr, ovf
    );

    modport slave (
        input  baud_k, eight, pen, ohel, read,
        output rx_data, rxrdy, perr, ferr, ovf
    );
endinterface

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive engine with mid-bit sampling
//
// Finds the start bit on the asynchronous rx line, samples each bit at
// mid-bit time from a per-bit cycle count and latches 7/8-bit characters
// with optional odd/even parity and framing/overrun flags.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   rx     serial line, idle high, asynchronous to clk
//   bus    uart_rx_engine_if.slave (baud_k, eight, pen, ohel, read in;
//          rx_data, rxrdy, perr, ferr, ovf out)
// Build option: UART_RX_MAJORITY_EN makes every bit decision a 2-of-3 vote
// over the cycles around the nominal sample point, one cycle later.
module uart_rx_engine (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    uart_rx_engine_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    state_t      state_nx;

    logic        sync1;
    logic        rxs;
    logic [18:0] cnt;
    logic [3:0]  nbits;
    logic [8:0]  sr;
    logic        expire;
    logic        bit_val;
    logic [3:0]  nb;

    logic        load_half;
    logic        load_full;
    logic        shift_en;
    logic        frame_done;

    logic [7:0]  data_w;
    logic        par_bit;
    logic        perr_w;
    logic        ferr_w;

    logic [7:0]  rx_data_q;
    logic        rxrdy_q;
    logic        perr_q;
    logic        ferr_q;
    logic        ovf_q;

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the cycle after the nominal point, so the whole frame
    // schedule is pushed out by one cycle through the first count load.
    localparam logic [18:0] START_EXTRA = 19'd1;
    logic hist1;
    logic hist2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist1 <= 1'b1;
            hist2 <= 1'b1;
        end else begin
            hist1 <= rxs;
            hist2 <= hist1;
        end
    end

    assign bit_val = (rxs & hist1) | (rxs & hist2) | (hist1 & hist2);
`else
    localparam logic [18:0] START_EXTRA = 19'd0;
    assign bit_val = rxs;
`endif

    // Count is loaded with the interval length and expires when it reaches 1,
    // so a load of N lands the decision exactly N cycles later.
    assign expire = (cnt == 19'd1);
    assign nb     = (bus.eight ? 4'd8 : 4'd7) + {3'b000, bus.pen};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    load_half = 1'b1;
                    state_nx  = START;
                end
            end
            START: begin
                if (expire) begin
                    if (!bit_val) begin
                        load_full = 1'b1;
                        state_nx  = DATA;
                    end else begin
                        state_nx  = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (nbits == nb - 4'd1) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            cnt   <= 19'd0;
            nbits <= 4'd0;
            sr    <= 9'd0;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            if (load_half) begin
                cnt <= (bus.baud_k >> 1) + START_EXTRA;
            end else if (load_full) begin
                cnt <= bus.baud_k;
            end else if (cnt != 19'd0) begin
                cnt <= cnt - 19'd1;
            end
            if (load_half) begin
                nbits <= 4'd0;
                sr    <= 9'd0;
            end else if (shift_en) begin
                sr[nbits] <= bit_val;
                nbits     <= nbits + 4'd1;
            end
        end
    end

    // Data bits sit at sr[0..], the parity bit right after the last data bit.
    assign data_w  = bus.eight ? sr[7:0] : {1'b0, sr[6:0]};
    assign par_bit = bus.eight ? sr[8] : sr[7];
    assign perr_w  = bus.pen & ((^data_w ^ par_bit) != bus.ohel);
    assign ferr_w  = ~bit_val;

    // Set-dominant flags: a completion wins over a simultaneous read, but that
    // read still retires the overrun since the old character was consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q <= 8'h00;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (frame_done) begin
            rx_data_q <= data_w;
            rxrdy_q   <= 1'b1;
            perr_q    <= perr_w;
            ferr_q    <= ferr_w;
            ovf_q     <= bus.read ? 1'b0 : (ovf_q | rxrdy_q);
        end else if (bus.read) begin
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rxrdy   = rxrdy_q;
    assign bus.perr    = perr_q;
    assign bus.ferr    = ferr_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Receive half of the UART. It takes the asynchronous serial line, finds each start bit and samples every bit at mid-bit time from a per-bit cycle count. It reassembles 7- or 8-bit characters with optional odd/even parity and presents the byte together with a ready flag and error flags for the register interface. It pairs with the transmit engine and uses the same baud divisor and framing control bits.

## Interface
- No parameters; framing and baud are runtime inputs.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset, one clock domain.
- rx  in  1  serial line, idle high, asynchronous to clk.
- baud_k  in  19  clock cycles per bit; legal range 16..2^19-1; must be stable while a frame is in progress.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 1 = odd, 0 = even; ignored when pen=0.
- read  in  1  one-cycle pulse: host consumed the data; clears rxrdy, perr, ferr and ovf.
- rx_data  out  8  received character, LSB first on the line; bit 7 = 0 in 7-bit mode.
- rxrdy  out  1  character available.
- perr  out  1  parity error on the latched character.
- ferr  out  1  framing error (stop bit sampled 0).
- ovf  out  1  overrun: a new character completed while rxrdy was already 1.

## Operation
- rx passes through a 2-flop synchronizer, reset value 1; rxs is its output.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when rxs==0, load the bit counter with baud_k>>1 and go to START.
- START: when the count expires, re-check rxs. If rxs==0, load baud_k and go to DATA. If rxs==1 it was a false start: go back to IDLE with no flag change.
- DATA: at each expiry, sample a bit and shift it into a shift register, LSB first. Bit count nb = (eight ? 8 : 7) + pen. After nb samples, go to STOP.
- Parity check: XOR of the data bits XOR the parity bit must equal ohel; otherwise the parity error is set.
- STOP: at expiry, sample the stop bit and latch the frame:
  - rx_data gets the data bits (bit 7 = 0 when eight=0).
  - perr and ferr get this frame's results.
  - rxrdy is set.
  - ovf is set if rxrdy was already 1; ovf is sticky until read.
  - The FSM returns to IDLE, even when ferr=1.
- A held-low line (break) gives repeated frames with ferr=1 and data 0x00.
- Flags behave as set-dominant SR flops:
  - set on frame completion, cleared by read;
  - a completion in the same cycle as read leaves rxrdy=1 and loads the new frame's perr/ferr;
  - ovf is cleared by that read, because the old data was consumed.
- Reset values: rx_data=0x00, rxrdy=0, perr=0, ferr=0, ovf=0, FSM=IDLE.
- Reset mid-frame aborts the frame with no flags set. After reset deasserts, reception resumes only at a fresh start bit seen in IDLE.

## Timing
- Define t0 as the first cycle with rxs==0 in IDLE; rxs lags rx by 2 cycles.
- Start re-check at t0 + floor(baud_k/2).
- Data/parity bit i (i = 0..nb-1) is sampled at t0 + floor(baud_k/2) + (i+1)·baud_k.
- Stop bit is sampled at t0 + floor(baud_k/2) + (nb+1)·baud_k.
- rx_data and the flags are valid, and rxrdy rises, on the clock after the stop sample.
- The FSM is in IDLE on that same clock, so back-to-back frames are accepted with no gap beyond the stop bit.
- read takes effect on the next clock edge; there is no combinational path from read to any output.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - each bit decision (start re-check, data, parity, stop) is the 2-of-3 majority of rxs at the nominal sample cycle −1, 0 and +1;
  - decisions, rxrdy and the flags occur 1 cycle later than the Timing section states.
- Undefined: a single sample at the nominal cycle, with exactly the Timing section's latencies.

## Test plan
- 8N1 frame: baud_k=868, eight=1, pen=0, send 0xA5 → rxrdy=1 one clock after the stop sample; rx_data=0xA5, perr=0, ferr=0, ovf=0; then read → all flags 0.
- 7-bit with parity: eight=0, pen=1, ohel=1 (odd), send 0x41 with a correct odd parity bit → rx_data=0x41, perr=0. Repeat with the parity bit inverted → perr=1, data still 0x41.
- Framing error and false start:
  - stop bit driven 0 → ferr=1, rxrdy=1;
  - a 3-cycle low glitch on the idle line with baud_k=868 → no rxrdy, FSM back to IDLE.
- Overrun and simultaneous events:
  - two back-to-back frames 0x12, 0x34 with no read → rx_data=0x34, ovf=1;
  - a read pulse in the same cycle as the second completion → rxrdy=1, ovf=0.
- Reset mid-frame: assert reset during data bit 3 → all outputs take reset values immediately. The next full frame 0x5A after reset deasserts is received correctly.
- UART_RX_MAJORITY_EN defined: a single-cycle inverted glitch exactly at the mid-bit sample of bit 2 in 0xFF → rx_data=0xFF. Without the macro, the same stimulus gives rx_data=0xFB.
